lif_neuron_array: RTL

//  Time-multiplexed array of leaky integrate-and-fire neurons; successor to the single-neuron LIF core.
//  One shared update datapath scans N_NEURONS membrane registers, one neuron per cycle, per timestep.

---
 rtl/lif_neuron_array_if.sv | 28 ++
 rtl/lif_neuron_array.sv | 114 +++++++++++
 2 files changed

// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: scan control, current/threshold inputs, spike and monitor outputs.
// master = stimulus/current source side, slave = neuron array.
interface lif_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int W         = 8
);
    localparam int IW = $clog2(N_NEURONS);

    logic                 start;
    logic [W-1:0]         thresh;
    logic [W-1:0]         cur_in;
    logic [IW-1:0]        mon_sel;
    logic [IW-1:0]        cur_idx;
    logic                 busy;
    logic                 done;
    logic [N_NEURONS-1:0] spikes;
    logic [W-1:0]         v_mon;

    modport master (
        output start, thresh, cur_in, mon_sel,
        input  cur_idx, busy, done, spikes, v_mon
    );

    modport slave (
        input  start, thresh, cur_in, mon_sel,
        output cur_idx, busy, done, spikes, v_mon
    );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: one shared update datapath, one neuron per cycle.
// Optional macro LIF_SOFT_RESET_EN: on spike keep residue (v - thresh) instead of clearing v to 0.
module lif_neuron_array #(
    parameter int N_NEURONS    = 4,
    parameter int W            = 8,
    parameter int LEAK_SHIFT   = 1,
    parameter int REFRAC_STEPS = 2
) (
    input logic              clk,
    input logic              rst_n,
    lif_neuron_array_if.slave bus
);
    localparam int IW = $clog2(N_NEURONS);
    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic                 busy_r;
    logic                 done_r;
    logic [N_NEURONS-1:0] spikes_r;
    logic [W-1:0]         v       [N_NEURONS];
    logic [RW-1:0]        ref_cnt [N_NEURONS];

    logic [W-1:0] v_cur;
    logic [W-1:0] leak;
    logic [W:0]   sum;
    logic [W-1:0] v_new;
    logic [W-1:0] v_fire;
    logic         refractory;
    logic         fire;

    // Shared datapath: leak, integrate and saturate the neuron selected by idx.
    always_comb begin
        v_cur      = v[idx];
        leak       = v_cur >> LEAK_SHIFT;
        sum        = {1'b0, v_cur} - {1'b0, leak} + {1'b0, bus.cur_in};
        v_new      = sum[W] ? '1 : sum[W-1:0];
        refractory = (ref_cnt[idx] != '0);
        fire       = !refractory && (v_new >= bus.thresh);
`ifdef LIF_SOFT_RESET_EN
        v_fire     = v_new - bus.thresh;
`else
        v_fire     = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            spikes_r <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v[i]       <= '0;
                ref_cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    idx    <= '0;
                    if (bus.start) begin
                        state    <= SCAN;
                        busy_r   <= 1'b1;
                        spikes_r <= '0;
                    end
                end
                SCAN: begin
                    if (refractory) begin
                        ref_cnt[idx] <= ref_cnt[idx] - 1'b1;
                    end else if (fire) begin
                        v[idx]        <= v_fire;
                        ref_cnt[idx]  <= RW'(REFRAC_STEPS);
                        spikes_r[idx] <= 1'b1;
                    end else begin
                        v[idx] <= v_new;
                    end
                    if (idx == IW'(N_NEURONS - 1)) begin
                        state  <= DONE;
                        idx    <= '0;
                        done_r <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    idx    <= '0;
                end
            endcase
        end
    end

    assign bus.cur_idx = idx;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.spikes  = spikes_r;
    // Out-of-range selects (non power-of-two arrays) read as zero.
    assign bus.v_mon   = (32'(bus.mon_sel) < N_NEURONS) ? v[bus.mon_sel] : '0;
endmodule
